// File: rtl/mux8way_collector_pkg.sv
// Shared constants and channel-slice convention for the 8-way
// mux/demux stream blocks.
package mux8way_collector_pkg;

  localparam int NUM_CH    = 8;
  localparam int SEL_W     = 3;
  localparam int DEF_WIDTH = 16;

  typedef logic [SEL_W-1:0] ch_idx_t;

  // Channel ch occupies [ch*width +: width] of a flat bus.
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/mux8way_collector_arbiter.sv
// Combinational 8-way round-robin arbiter: first requester at or
// after ptr, wrapping modulo 8.
module rr_arbiter8
  import mux8way_collector_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_idx_t           ptr,
  output logic              grant_valid,
  output ch_idx_t           grant_idx
);

  logic [2*NUM_CH-1:0] w_dbl;
  logic [NUM_CH-1:0]   w_rot;
  ch_idx_t             w_off;

  // w_rot[k] is the request of channel (ptr + k) mod 8.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[ptr +: NUM_CH];

  always_comb begin
    w_off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SEL_W'(i);
    end
  end

  assign grant_valid = |req;
  assign grant_idx   = ptr + w_off;

endmodule

// File: rtl/mux8way_collector.sv
// Eight-channel valid/ready stream merger with round-robin
// arbitration into one registered output slot.
module mux8way_collector
  import mux8way_collector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]  r_data;
  ch_idx_t           r_sel;
  logic              r_valid;
  ch_idx_t           r_ptr;

  logic              w_load;
  logic              w_gv;
  ch_idx_t           w_gidx;
  logic              w_xfer;
  logic [WIDTH-1:0]  w_word;
  logic [NUM_CH-1:0] w_ready;

  rr_arbiter8 u_arb (
    .req         (in_valid),
    .ptr         (r_ptr),
    .grant_valid (w_gv),
    .grant_idx   (w_gidx)
  );

  assign w_load = ~r_valid | out_ready;
  assign w_xfer = w_load & w_gv;

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gidx == SEL_W'(i))
        w_word = in_data[ch_lsb(i, WIDTH) +: WIDTH];
    end
  end

  // No acceptance is signalled while reset is held.
  always_comb begin
    w_ready = '0;
    if (rst_n && w_xfer) w_ready[w_gidx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_data  <= w_word;
      r_sel   <= w_gidx;
      r_valid <= 1'b1;
      r_ptr   <= w_gidx + SEL_W'(1);
    end else if (w_load) begin
      r_valid <= 1'b0;
    end
  end

  assign in_ready  = w_ready;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux8way_collector.sv
// Self-checking bench for mux8way_collector: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_mux8way_collector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [7:0]   in_valid;
  logic [7:0]   in_ready;
  logic [15:0]  out_data;
  logic [2:0]   out_sel;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  bit          m_valid;
  logic [15:0] m_data;
  int          m_sel;
  int          m_ptr;

  always #5 clk = ~clk;

  mux8way_collector #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic int pick(input logic [7:0] v,
                              input int p);
    for (int k = 0; k < 8; k++) begin
      if (v[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_ready();
    int  g;
    bit  load;
    logic [7:0] r;
    g    = pick(in_valid, m_ptr);
    load = !m_valid || out_ready;
    r    = 8'h00;
    if (load && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = 16'h0000;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  task automatic set_ch(input int ch, input logic [15:0] v);
    in_data[ch*16 +: 16] = v;
  endtask

  // Advance one clock; model consumes the inputs seen at the edge.
  task automatic tick();
    int g;
    bit load;
    g    = pick(in_valid, m_ptr);
    load = !m_valid || out_ready;
    @(posedge clk);
    if (load && g >= 0) begin
      m_data  = in_data[g*16 +: 16];
      m_sel   = g;
      m_valid = 1;
      m_ptr   = (g + 1) % 8;
    end else if (load) begin
      m_valid = 0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 8'h00;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({out_valid, out_data, out_sel, in_ready} !== 28'h0) begin
        errors++;
        $display("FAIL reset_hold: v=%b d=%h s=%0d r=%h want 0",
                 out_valid, out_data, out_sel, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({out_valid, out_data, out_sel, in_ready} !== 28'h0) begin
        errors++;
        $display("FAIL reset_idle: v=%b d=%h s=%0d r=%h want 0",
                 out_valid, out_data, out_sel, in_ready);
      end
      tick();
    end
  endtask

  task automatic test_single();
    set_ch(3, 16'hBEEF);
    set_ch(4, 16'h4444);
    in_valid  = 8'h08;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 8'h08) begin
      errors++;
      $display("FAIL single_ready: got %h want 08", in_ready);
    end
    tick();
    in_valid = 8'h18;
    #1;
    checks++;
    if ({out_valid, out_data, out_sel} !== {1'b1, 16'hBEEF, 3'd3}) begin
      errors++;
      $display("FAIL single_out: v=%b d=%h s=%0d want 1 BEEF 3",
               out_valid, out_data, out_sel);
    end
    checks++;
    if (in_ready !== 8'h10) begin
      errors++;
      $display("FAIL single_ptr4: got %h want 10", in_ready);
    end
    tick();
    in_valid = 8'h00;
    tick();
    checks++;
    if ({out_valid, out_data, out_sel} !== {1'b0, 16'h4444, 3'd4}) begin
      errors++;
      $display("FAIL single_drain: v=%b d=%h s=%0d want 0 4444 4",
               out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_rr_wrap();
    logic [7:0] want;
    do_reset();
    for (int i = 0; i < 8; i++) set_ch(i, 16'h1000 + 16'(i));
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      want = 8'h01 << (k % 8);
      checks++;
      if (in_ready !== want) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %h want %h",
                 k, in_ready, want);
      end
      tick();
      checks++;
      if (!out_valid || out_sel !== 3'(k % 8) ||
          out_data !== 16'h1000 + 16'(k % 8)) begin
        errors++;
        $display("FAIL rr_out[%0d]: v=%b s=%0d d=%h want s=%0d",
                 k, out_valid, out_sel, out_data, k % 8);
      end
    end
    in_valid = 8'h00;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_ch(5, 16'h00A5);
    set_ch(6, 16'h00A6);
    in_valid  = 8'h60;
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 8'h20) begin
      errors++;
      $display("FAIL bp_first: got %h want 20", in_ready);
    end
    tick();
    in_valid = 8'h40;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({out_valid, out_data, out_sel, in_ready} !==
          {1'b1, 16'h00A5, 3'd5, 8'h00}) begin
        errors++;
        $display("FAIL bp_stall[%0d]: v=%b d=%h s=%0d r=%h",
                 c, out_valid, out_data, out_sel, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 8'h40) begin
      errors++;
      $display("FAIL bp_release: got %h want 40", in_ready);
    end
    tick();
    in_valid = 8'h00;
    #1;
    checks++;
    if ({out_valid, out_data, out_sel} !== {1'b1, 16'h00A6, 3'd6}) begin
      errors++;
      $display("FAIL bp_next: v=%b d=%h s=%0d want 1 00A6 6",
               out_valid, out_data, out_sel);
    end
    tick();
  endtask

  task automatic test_ptr_priority();
    do_reset();
    set_ch(0, 16'h0C00);
    set_ch(6, 16'h0C06);
    in_valid  = 8'h40;
    out_ready = 1'b1;
    tick();
    in_valid = 8'h41;
    #1;
    checks++;
    if (in_ready !== 8'h01) begin
      errors++;
      $display("FAIL prio_wrap: got %h want 01", in_ready);
    end
    tick();
    in_valid = 8'h40;
    #1;
    checks++;
    if (out_sel !== 3'd0 || out_data !== 16'h0C00 ||
        in_ready !== 8'h40) begin
      errors++;
      $display("FAIL prio_ch0: s=%0d d=%h r=%h want 0 0C00 40",
               out_sel, out_data, in_ready);
    end
    tick();
    in_valid = 8'h00;
    #1;
    checks++;
    if (out_sel !== 3'd6 || !out_valid) begin
      errors++;
      $display("FAIL prio_ch6: s=%0d v=%b want 6 1",
               out_sel, out_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    for (int i = 0; i < 8; i++) set_ch(i, 16'h2000 + 16'(i));
    in_valid  = 8'h04;
    out_ready = 1'b0;
    tick();
    in_valid = 8'hFF;
    #1;
    checks++;
    if (!out_valid || in_ready !== 8'h00) begin
      errors++;
      $display("FAIL mid_stall: v=%b r=%h want 1 00",
               out_valid, in_ready);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_sel, in_ready} !== 28'h0) begin
      errors++;
      $display("FAIL mid_async: v=%b d=%h s=%0d r=%h want 0",
               out_valid, out_data, out_sel, in_ready);
    end
    model_reset();
    @(negedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 8'h01) begin
      errors++;
      $display("FAIL mid_first: got %h want 01", in_ready);
    end
    tick();
    in_valid = 8'h00;
    tick();
  endtask

  task automatic test_fairness();
    int wait_n;
    int worst;
    wait_n    = 0;
    worst     = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < 8; i++) set_ch(i, 16'($urandom));
      in_valid = 8'($urandom) | 8'h04;
      #1;
      if (in_ready[2]) wait_n = 0;
      else if (in_ready != 8'h00) wait_n++;
      if (wait_n > worst) worst = wait_n;
      tick();
    end
    checks++;
    if (worst > 7) begin
      errors++;
      $display("FAIL fairness: waited %0d grants want <= 7", worst);
    end
    in_valid = 8'h00;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] want;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 8; i++) set_ch(i, 16'($urandom));
      in_valid  = ($urandom_range(0, 3) == 0) ? 8'h00
                                              : 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      want = exp_ready();
      checks++;
      if (in_ready !== want) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %h want %h",
                 c, in_ready, want);
      end
      checks++;
      if (out_valid !== m_valid || out_data !== m_data ||
          out_sel !== 3'(m_sel)) begin
        errors++;
        $display("FAIL rand_out[%0d]: v=%b d=%h s=%0d want %b %h %0d",
                 c, out_valid, out_data, out_sel,
                 m_valid, m_data, m_sel);
      end
      tick();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 8'h00;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    test_reset();
    test_single();
    test_rr_wrap();
    test_backpressure();
    test_ptr_priority();
    test_reset_mid_stall();
    test_fairness();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
